// File: rtl/sc_game_pkg.sv
// Shared game constants and state encoding for the Frogger lives/levels datapath.
`timescale 1ns/1ps
package sc_game_pkg;

    localparam int unsigned CNT_WIDTH  = 3;
    localparam int unsigned INIT_LIVES = 3;
    localparam int unsigned MAX_LIVES  = 7;
    localparam int unsigned WIN_LEVEL  = 5;

    typedef enum logic [1:0] {
        PLAYING   = 2'd0,
        GAME_OVER = 2'd1,
        WON       = 2'd2
    } game_state_e;

endpackage

// File: rtl/sc_lives_levels_counter_if.sv
// Command strobes from the game FSM and the count/status values returned to it.
`timescale 1ns/1ps
interface sc_lives_levels_counter_if #(
    parameter int unsigned CNT_WIDTH = sc_game_pkg::CNT_WIDTH
);
    logic                 SC_LIVESLEVELS_clear_InLow;
    logic                 SC_LIVESLEVELS_livesDec_InLow;
    logic                 SC_LIVESLEVELS_livesInc_InLow;
    logic                 SC_LIVESLEVELS_levelInc_InLow;
    logic [CNT_WIDTH-1:0] SC_LIVESLEVELS_lives_Out;
    logic [CNT_WIDTH-1:0] SC_LIVESLEVELS_level_Out;
    logic                 SC_LIVESLEVELS_COMPARATOR_LIVES;
    logic                 SC_LIVESLEVELS_COMPARATOR_LEVELS;
    logic                 SC_LIVESLEVELS_gameOver_Out;
    logic                 SC_LIVESLEVELS_won_Out;

    // Game FSM side: issues commands, reads counts and flags.
    modport master (
        output SC_LIVESLEVELS_clear_InLow, SC_LIVESLEVELS_livesDec_InLow,
               SC_LIVESLEVELS_livesInc_InLow, SC_LIVESLEVELS_levelInc_InLow,
        input  SC_LIVESLEVELS_lives_Out, SC_LIVESLEVELS_level_Out,
               SC_LIVESLEVELS_COMPARATOR_LIVES, SC_LIVESLEVELS_COMPARATOR_LEVELS,
               SC_LIVESLEVELS_gameOver_Out, SC_LIVESLEVELS_won_Out
    );

    // Counter side: responds to commands, drives counts and flags.
    modport slave (
        input  SC_LIVESLEVELS_clear_InLow, SC_LIVESLEVELS_livesDec_InLow,
               SC_LIVESLEVELS_livesInc_InLow, SC_LIVESLEVELS_levelInc_InLow,
        output SC_LIVESLEVELS_lives_Out, SC_LIVESLEVELS_level_Out,
               SC_LIVESLEVELS_COMPARATOR_LIVES, SC_LIVESLEVELS_COMPARATOR_LEVELS,
               SC_LIVESLEVELS_gameOver_Out, SC_LIVESLEVELS_won_Out
    );
endinterface

// File: rtl/sc_edge_detect_low.sv
// Falling-edge qualifier for an active-low strobe: one pulse per assertion.
`timescale 1ns/1ps
module sc_edge_detect_low (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic strobe_n_i,
    output logic pulse_c_o
);
    logic hist_q;

    // History of the strobe; reset to the deasserted level so a strobe held
    // low across reset release still fires once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) hist_q <= 1'b1;
        else         hist_q <= strobe_n_i;
    end

    assign pulse_c_o = ~strobe_n_i & hist_q;
endmodule

// File: rtl/sc_lives_levels_counter.sv
// Lives/levels bookkeeping for the Frogger game FSM.
// Optional build macro: SC_LIVESLEVELS_BONUS_LIFE_EN (each level advance also
// grants one life, cancelled by a simultaneous life loss).
`timescale 1ns/1ps
module sc_lives_levels_counter #(
    parameter int unsigned INIT_LIVES = sc_game_pkg::INIT_LIVES,
    parameter int unsigned MAX_LIVES  = sc_game_pkg::MAX_LIVES,
    parameter int unsigned WIN_LEVEL  = sc_game_pkg::WIN_LEVEL,
    parameter int unsigned CNT_WIDTH  = sc_game_pkg::CNT_WIDTH
) (
    input  logic                      SC_LIVESLEVELS_CLOCK_50,
    input  logic                      SC_LIVESLEVELS_RESET_InLow,
    sc_lives_levels_counter_if.slave  bus
);
    import sc_game_pkg::*;

    localparam int unsigned SUM_W = CNT_WIDTH + 2;

    logic                 dec_p, inc_p, lvl_p;
    logic [1:0]           up_c;
    logic [SUM_W-1:0]     sum_c;
    game_state_e          state_q, state_d;
    logic [CNT_WIDTH-1:0] lives_q, lives_d;
    logic [CNT_WIDTH-1:0] level_q, level_d;
    logic                 comp_lives_q, comp_levels_q, game_over_q, won_q;

    sc_edge_detect_low u_dec (
        .clk_i(SC_LIVESLEVELS_CLOCK_50), .rst_ni(SC_LIVESLEVELS_RESET_InLow),
        .strobe_n_i(bus.SC_LIVESLEVELS_livesDec_InLow), .pulse_c_o(dec_p)
    );
    sc_edge_detect_low u_inc (
        .clk_i(SC_LIVESLEVELS_CLOCK_50), .rst_ni(SC_LIVESLEVELS_RESET_InLow),
        .strobe_n_i(bus.SC_LIVESLEVELS_livesInc_InLow), .pulse_c_o(inc_p)
    );
    sc_edge_detect_low u_lvl (
        .clk_i(SC_LIVESLEVELS_CLOCK_50), .rst_ni(SC_LIVESLEVELS_RESET_InLow),
        .strobe_n_i(bus.SC_LIVESLEVELS_levelInc_InLow), .pulse_c_o(lvl_p)
    );

    // Saturating lives update; a gain and a loss in the same cycle cancel.
    always_comb begin
        up_c = {1'b0, inc_p};
`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
        up_c = up_c + {1'b0, lvl_p};
`endif
        sum_c = SUM_W'(lives_q) + SUM_W'(up_c);
        if (sum_c >= SUM_W'(dec_p)) sum_c = sum_c - SUM_W'(dec_p);
        else                        sum_c = '0;
        if (sum_c > SUM_W'(MAX_LIVES)) sum_c = SUM_W'(MAX_LIVES);
    end

    // Next state: clear dominates; commands only act while playing.
    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        level_d = level_q;
        if (!bus.SC_LIVESLEVELS_clear_InLow) begin
            state_d = PLAYING;
            lives_d = CNT_WIDTH'(INIT_LIVES);
            level_d = '0;
        end else if (state_q == PLAYING) begin
            lives_d = CNT_WIDTH'(sum_c);
            if (lvl_p && (level_q < CNT_WIDTH'(WIN_LEVEL))) begin
                level_d = level_q + CNT_WIDTH'(1);
            end
            // Running out of lives takes precedence over reaching the win level.
            if (lives_d == '0)                           state_d = GAME_OVER;
            else if (level_d == CNT_WIDTH'(WIN_LEVEL))   state_d = WON;
        end
    end

    // State, counters and registered status flags.
    always_ff @(posedge SC_LIVESLEVELS_CLOCK_50 or negedge SC_LIVESLEVELS_RESET_InLow) begin
        if (!SC_LIVESLEVELS_RESET_InLow) begin
            state_q       <= PLAYING;
            lives_q       <= CNT_WIDTH'(INIT_LIVES);
            level_q       <= '0;
            comp_lives_q  <= (INIT_LIVES != 0);
            comp_levels_q <= (WIN_LEVEL == 0);
            game_over_q   <= 1'b0;
            won_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            comp_lives_q  <= (lives_d != '0);
            comp_levels_q <= (level_d == CNT_WIDTH'(WIN_LEVEL));
            game_over_q   <= (state_d == GAME_OVER);
            won_q         <= (state_d == WON);
        end
    end

    assign bus.SC_LIVESLEVELS_lives_Out         = lives_q;
    assign bus.SC_LIVESLEVELS_level_Out         = level_q;
    assign bus.SC_LIVESLEVELS_COMPARATOR_LIVES  = comp_lives_q;
    assign bus.SC_LIVESLEVELS_COMPARATOR_LEVELS = comp_levels_q;
    assign bus.SC_LIVESLEVELS_gameOver_Out      = game_over_q;
    assign bus.SC_LIVESLEVELS_won_Out           = won_q;
endmodule

// File: tb/tb_sc_lives_levels_counter.sv
// Directed bench for sc_lives_levels_counter.
`timescale 1ns/1ps
module tb_sc_lives_levels_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [9:0] obs;

    sc_lives_levels_counter_if #(.CNT_WIDTH(3)) bus ();

    sc_lives_levels_counter dut (
        .SC_LIVESLEVELS_CLOCK_50    (clk),
        .SC_LIVESLEVELS_RESET_InLow (rst_n),
        .bus                        (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // {lives, level, COMPARATOR_LIVES, COMPARATOR_LEVELS, gameOver, won}
    assign obs = {bus.SC_LIVESLEVELS_lives_Out, bus.SC_LIVESLEVELS_level_Out,
                  bus.SC_LIVESLEVELS_COMPARATOR_LIVES, bus.SC_LIVESLEVELS_COMPARATOR_LEVELS,
                  bus.SC_LIVESLEVELS_gameOver_Out, bus.SC_LIVESLEVELS_won_Out};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_strobes();
        bus.SC_LIVESLEVELS_clear_InLow    = 1'b1;
        bus.SC_LIVESLEVELS_livesDec_InLow = 1'b1;
        bus.SC_LIVESLEVELS_livesInc_InLow = 1'b1;
        bus.SC_LIVESLEVELS_levelInc_InLow = 1'b1;
    endtask

    task automatic do_clear();
        bus.SC_LIVESLEVELS_clear_InLow = 1'b0;
        tick();
        bus.SC_LIVESLEVELS_clear_InLow = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        logic [9:0] exp;
        rst_n = 1'b0;
        idle_strobes();
        repeat (2) @(posedge clk);
        #3;
        exp = {3'd3, 3'd0, 4'b1000};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_held got=%b exp=%b", obs, exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_release got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_lives_dec();
        logic [9:0] exp;
        logic [2:0] el;
        for (int i = 0; i < 3; i++) begin
            bus.SC_LIVESLEVELS_livesDec_InLow = 1'b0;
            el = 3'(2 - i);
            exp = {el, 3'd0, (el != 3'd0), 1'b0, (el == 3'd0), 1'b0};
            for (int c = 0; c < 4; c++) begin
                tick();
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL dec_step%0d_cyc%0d got=%b exp=%b", i, c, obs, exp);
                end
            end
            bus.SC_LIVESLEVELS_livesDec_InLow = 1'b1;
            tick();
        end
        bus.SC_LIVESLEVELS_livesInc_InLow = 1'b0;
        tick();
        bus.SC_LIVESLEVELS_livesInc_InLow = 1'b1;
        tick();
        exp = {3'd0, 3'd0, 4'b0010};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL inc_in_game_over got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_clear_priority();
        logic [9:0] exp;
        bus.SC_LIVESLEVELS_clear_InLow    = 1'b0;
        bus.SC_LIVESLEVELS_livesDec_InLow = 1'b0;
        tick();
        exp = {3'd3, 3'd0, 4'b1000};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL clear_with_dec got=%b exp=%b", obs, exp);
        end
        idle_strobes();
        tick();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL clear_release got=%b exp=%b", obs, exp);
        end
    endtask

    task automatic test_levels();
        logic [9:0] exp;
        logic [2:0] el;
        logic [2:0] ll;
        for (int i = 1; i <= 6; i++) begin
            bus.SC_LIVESLEVELS_levelInc_InLow = 1'b0;
            tick();
            bus.SC_LIVESLEVELS_levelInc_InLow = 1'b1;
            tick();
            el = (i > 5) ? 3'd5 : 3'(i);
`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
            ll = (3 + i > 7) ? 3'd7 : 3'(3 + i);
`else
            ll = 3'd3;
`endif
            exp = {ll, el, 1'b1, (el == 3'd5), 1'b0, (el == 3'd5)};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL level_pulse%0d got=%b exp=%b", i, obs, exp);
            end
        end
        do_clear();
    endtask

    task automatic test_lives_sat();
        logic [9:0] exp;
        logic [2:0] ll;
        for (int i = 1; i <= 5; i++) begin
            bus.SC_LIVESLEVELS_livesInc_InLow = 1'b0;
            tick();
            bus.SC_LIVESLEVELS_livesInc_InLow = 1'b1;
            tick();
            ll = (3 + i > 7) ? 3'd7 : 3'(3 + i);
            exp = {ll, 3'd0, 4'b1000};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL inc_pulse%0d got=%b exp=%b", i, obs, exp);
            end
        end
        bus.SC_LIVESLEVELS_livesInc_InLow = 1'b0;
        bus.SC_LIVESLEVELS_livesDec_InLow = 1'b0;
        tick();
        idle_strobes();
        tick();
        exp = {3'd7, 3'd0, 4'b1000};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL inc_dec_same_cycle got=%b exp=%b", obs, exp);
        end
        do_clear();
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp;
        int         n_dec;
        for (int i = 0; i < 4; i++) begin
            bus.SC_LIVESLEVELS_levelInc_InLow = 1'b0;
            tick();
            bus.SC_LIVESLEVELS_levelInc_InLow = 1'b1;
            tick();
        end
`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
        n_dec = 6;
`else
        n_dec = 2;
`endif
        for (int i = 0; i < n_dec; i++) begin
            bus.SC_LIVESLEVELS_livesDec_InLow = 1'b0;
            tick();
            bus.SC_LIVESLEVELS_livesDec_InLow = 1'b1;
            tick();
        end
        exp = {3'd1, 3'd4, 4'b1000};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL setup_one_life got=%b exp=%b", obs, exp);
        end
        bus.SC_LIVESLEVELS_livesDec_InLow = 1'b0;
        bus.SC_LIVESLEVELS_levelInc_InLow = 1'b0;
        tick();
`ifdef SC_LIVESLEVELS_BONUS_LIFE_EN
        exp = {3'd1, 3'd5, 4'b1101};
`else
        exp = {3'd0, 3'd5, 4'b0110};
`endif
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL dec_and_level_together got=%b exp=%b", obs, exp);
        end
        idle_strobes();
        tick();
    endtask

    task automatic test_async_reset();
        logic [9:0] exp;
        @(posedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        exp = {3'd3, 3'd0, 4'b1000};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", obs, exp);
        end
        bus.SC_LIVESLEVELS_livesDec_InLow = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp = {3'd2, 3'd0, 4'b1000};
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL dec_across_reset got=%b exp=%b", obs, exp);
        end
        tick();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL dec_held_after_reset got=%b exp=%b", obs, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        idle_strobes();
        test_reset();
        test_lives_dec();
        test_clear_priority();
        test_levels();
        test_lives_sat();
        test_back_to_back();
        test_async_reset();
        test_clear_priority();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
